// File: rtl/lisa_ssa_regfile_mp.sv
// lisa_ssa_regfile_mp
// Multi-port SSA value store. Each SSA ID maps to a DATA_W-bit value plus a valid bit.
// The valid bit is set by the first write to an ID and cleared by retirement or a flush.
// A second write to a live ID is dropped and raises the sticky error flag.
//
// Ports
//   clk, rst_n       clock; synchronous active-low reset
//   flush            pulse that starts a bulk invalidate sweep
//   ready            1 when the store is usable, 0 while sweeping
//   raddr/rdata/rvalid  NUM_RD combinational read ports with write bypass
//   wen/waddr/wdata  NUM_WR write ports (the higher index wins an ID clash)
//   inv_en/inv_addr  retire one ID
//   live_cnt         number of currently valid IDs
//   err/err_addr     sticky single-assignment violation flag and the ID of the first violation
module lisa_ssa_regfile_mp #(
  parameter int NUM_REGS = 256,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int NUM_RD   = 3,
  parameter int NUM_WR   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  output logic                       ready,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  output logic [NUM_RD-1:0]          rvalid,
  input  logic [NUM_WR-1:0]          wen,
  input  logic [NUM_WR*ADDR_W-1:0]   waddr,
  input  logic [NUM_WR*DATA_W-1:0]   wdata,
  input  logic                       inv_en,
  input  logic [ADDR_W-1:0]          inv_addr,
  output logic [ADDR_W:0]            live_cnt,
  output logic                       err,
  output logic [ADDR_W-1:0]          err_addr
);

  typedef enum logic {SWEEP = 1'b0, RUN = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] LAST_ID = ADDR_W'(NUM_REGS - 1);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   ptr_reg, ptr_next;
  logic [NUM_REGS-1:0] valid_reg, valid_next;
  logic [ADDR_W:0]     live_reg, live_next;
  logic                err_reg, err_next;
  logic [ADDR_W-1:0]   err_addr_reg, err_addr_next;
  logic [DATA_W-1:0]   mem [NUM_REGS];

  // Writes and retirements only take effect in RUN with no flush and no reset pending.
  logic run_ops;
  assign run_ops = rst_n && (state_reg == RUN) && !flush;

  logic [ADDR_W-1:0] wa [NUM_WR];
  logic [DATA_W-1:0] wd [NUM_WR];
  logic [NUM_WR-1:0] accept;
  logic [NUM_WR-1:0] violate;

  generate
    for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_wr
      logic shadowed;
      assign wa[gi] = waddr[gi*ADDR_W +: ADDR_W];
      assign wd[gi] = wdata[gi*DATA_W +: DATA_W];

      // A write loses to any higher-index port that targets the same ID this cycle.
      always_comb begin
        shadowed = 1'b0;
        for (int k = gi + 1; k < NUM_WR; k++) begin
          if (wen[k] && (waddr[k*ADDR_W +: ADDR_W] == wa[gi])) shadowed = 1'b1;
        end
      end

      assign accept[gi]  = run_ops && wen[gi] && !valid_reg[wa[gi]] && !shadowed;
      assign violate[gi] = run_ops && wen[gi] && (valid_reg[wa[gi]] || shadowed);
    end

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd;
      logic              rv;
      assign ra = raddr[gi*ADDR_W +: ADDR_W];

      // At most one accepted write can target a given ID, so the bypass is unambiguous.
      always_comb begin
        rd = mem[ra];
        rv = valid_reg[ra];
        for (int j = 0; j < NUM_WR; j++) begin
          if (accept[j] && (wa[j] == ra)) begin
            rd = wd[j];
            rv = 1'b1;
          end
        end
        if (state_reg != RUN) begin
          rd = '0;
          rv = 1'b0;
        end
      end

      assign rdata[gi*DATA_W +: DATA_W] = rd;
      assign rvalid[gi]                 = rv;
    end
  endgenerate

  // A retirement is effective only on a live ID that is not also being written this cycle.
  // An accepted write implies the ID was invalid, so the second term is defensive.
  logic inv_hit;
  logic eff_inv;
  always_comb begin
    inv_hit = 1'b0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (accept[j] && (wa[j] == inv_addr)) inv_hit = 1'b1;
    end
  end
  assign eff_inv = run_ops && inv_en && valid_reg[inv_addr] && !inv_hit;

  always_comb begin
    logic [ADDR_W+1:0] sum;
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    valid_next    = valid_reg;
    live_next     = live_reg;
    err_next      = err_reg;
    err_addr_next = err_addr_reg;
    sum           = {1'b0, live_reg};
    case (state_reg)
      SWEEP: begin
        valid_next[ptr_reg] = 1'b0;
        if (flush) begin
          ptr_next = '0;
        end else if (ptr_reg == LAST_ID) begin
          ptr_next   = '0;
          state_next = RUN;
        end else begin
          ptr_next = ptr_reg + 1'b1;
        end
      end
      default: begin
        if (flush) begin
          state_next    = SWEEP;
          ptr_next      = '0;
          live_next     = '0;
          err_next      = 1'b0;
          err_addr_next = '0;
        end else begin
          // Clear first so that an accepted write to the same ID leaves it valid.
          if (eff_inv) valid_next[inv_addr] = 1'b0;
          for (int j = 0; j < NUM_WR; j++) begin
            if (accept[j]) begin
              valid_next[wa[j]] = 1'b1;
              sum = sum + (ADDR_W+2)'(1);
            end
          end
          if (eff_inv) sum = sum - (ADDR_W+2)'(1);
          live_next = sum[ADDR_W:0];
          if (|violate) begin
            err_next = 1'b1;
            if (!err_reg) begin
              // Walk downward so the lowest violating port is assigned last.
              for (int j = NUM_WR - 1; j >= 0; j--) begin
                if (violate[j]) err_addr_next = wa[j];
              end
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= SWEEP;
      ptr_reg      <= '0;
      live_reg     <= '0;
      err_reg      <= 1'b0;
      err_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      live_reg     <= live_next;
      err_reg      <= err_next;
      err_addr_reg <= err_addr_next;
    end
  end

  // Valid bits need no reset: the sweep that follows every reset clears them.
  always_ff @(posedge clk) begin
    valid_reg <= valid_next;
  end

  // The data array is never cleared; only accepted writes touch it.
  always_ff @(posedge clk) begin
    for (int j = 0; j < NUM_WR; j++) begin
      if (accept[j]) mem[wa[j]] <= wd[j];
    end
  end

  assign ready    = (state_reg == RUN);
  assign live_cnt = live_reg;
  assign err      = err_reg;
  assign err_addr = err_addr_reg;

endmodule

// File: tb/tb_lisa_ssa_regfile_mp.sv
module tb_lisa_ssa_regfile_mp;

  localparam int NUM_REGS = 256;
  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 32;
  localparam int NUM_RD   = 3;
  localparam int NUM_WR   = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     flush;
  logic                     ready;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rvalid;
  logic [NUM_WR-1:0]        wen;
  logic [NUM_WR*ADDR_W-1:0] waddr;
  logic [NUM_WR*DATA_W-1:0] wdata;
  logic                     inv_en;
  logic [ADDR_W-1:0]        inv_addr;
  logic [ADDR_W:0]          live_cnt;
  logic                     err;
  logic [ADDR_W-1:0]        err_addr;

  int tests = 0;
  int fails = 0;

  lisa_ssa_regfile_mp #(
    .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ready(ready),
    .raddr(raddr), .rdata(rdata), .rvalid(rvalid),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .inv_en(inv_en), .inv_addr(inv_addr),
    .live_cnt(live_cnt), .err(err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  wen;
    logic [7:0]  wa0;
    logic [31:0] wd0;
    logic [7:0]  wa1;
    logic [31:0] wd1;
    logic        inv;
    logic [7:0]  ia;
    logic [7:0]  ra;
    logic [31:0] erd;
    logic        erv;
    logic [8:0]  elive;
    logic        eerr;
    logic [7:0]  eea;
  } vec_t;

  function automatic vec_t mk(logic [1:0] w, logic [7:0] a0, logic [31:0] d0, logic [7:0] a1,
                              logic [31:0] d1, logic iv, logic [7:0] ia, logic [7:0] ra,
                              logic [31:0] erd, logic erv, logic [8:0] el, logic ee,
                              logic [7:0] eea);
    vec_t v;
    v.wen = w; v.wa0 = a0; v.wd0 = d0; v.wa1 = a1; v.wd1 = d1; v.inv = iv; v.ia = ia;
    v.ra = ra; v.erd = erd; v.erv = erv; v.elive = el; v.eerr = ee; v.eea = eea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One transaction: drive mid-cycle, check combinational reads, clock, check registers.
  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    wen      = v.wen;
    waddr    = {v.wa1, v.wa0};
    wdata    = {v.wd1, v.wd0};
    inv_en   = v.inv;
    inv_addr = v.ia;
    raddr    = {3{v.ra}};
    #1;
    for (int k = 0; k < NUM_RD; k++) begin
      chk($sformatf("%s rdata%0d", tag, k), 64'(rdata[k*DATA_W +: DATA_W]), 64'(v.erd));
    end
    chk($sformatf("%s rvalid", tag), 64'(rvalid), 64'({NUM_RD{v.erv}}));
    @(posedge clk);
    #1;
    wen    = '0;
    inv_en = 1'b0;
    chk($sformatf("%s live_cnt", tag), 64'(live_cnt), 64'(v.elive));
    chk($sformatf("%s err", tag), 64'(err), 64'(v.eerr));
    chk($sformatf("%s err_addr", tag), 64'(err_addr), 64'(v.eea));
    $display("[TB] %s wen=%b wa0=%h wa1=%h inv=%b ra=%h rd0=%h live=%0d err=%b",
             tag, v.wen, v.wa0, v.wa1, v.inv, v.ra, rdata[DATA_W-1:0], live_cnt, err);
  endtask

  // Read every ID on all ports and count any that report valid.
  task automatic scan_invalid(input string name);
    int bad = 0;
    for (int i = 0; i < NUM_REGS; i++) begin
      @(negedge clk);
      raddr = {3{8'(i)}};
      #1;
      if (rvalid !== '0) bad++;
    end
    chk(name, 64'(bad), 64'd0);
    $display("[TB] %s scanned %0d IDs", name, NUM_REGS);
  endtask

  vec_t vecs[15];
  vec_t fill[5];

  initial begin
    int cnt;
    int low;
    bit done;

    rst_n = 1'b0; flush = 1'b0; wen = '0; waddr = '0; wdata = '0;
    inv_en = 1'b0; inv_addr = '0; raddr = '0;

    //              wen    wa0    wd0           wa1    wd1      inv  ia     ra     erd           erv  live err ea
    vecs[0]  = mk(2'b01, 8'h05, 32'hDEADBEEF, 8'h00, 32'h0,    0, 8'h00, 8'h05, 32'hDEADBEEF, 1, 1, 0, 8'h00);
    vecs[1]  = mk(2'b00, 8'h00, 32'h0,        8'h00, 32'h0,    0, 8'h00, 8'h05, 32'hDEADBEEF, 1, 1, 0, 8'h00);
    vecs[2]  = mk(2'b01, 8'h05, 32'h12345678, 8'h00, 32'h0,    0, 8'h00, 8'h05, 32'hDEADBEEF, 1, 1, 1, 8'h05);
    vecs[3]  = mk(2'b00, 8'h00, 32'h0,        8'h00, 32'h0,    0, 8'h00, 8'h05, 32'hDEADBEEF, 1, 1, 1, 8'h05);
    vecs[4]  = mk(2'b01, 8'h07, 32'h77,       8'h00, 32'h0,    0, 8'h00, 8'h07, 32'h77,       1, 2, 1, 8'h05);
    vecs[5]  = mk(2'b01, 8'h07, 32'h99,       8'h00, 32'h0,    0, 8'h00, 8'h07, 32'h77,       1, 2, 1, 8'h05);
    vecs[6]  = mk(2'b11, 8'h10, 32'h1111,     8'h10, 32'h2222, 0, 8'h00, 8'h10, 32'h2222,     1, 3, 1, 8'h05);
    vecs[7]  = mk(2'b00, 8'h00, 32'h0,        8'h00, 32'h0,    0, 8'h00, 8'h10, 32'h2222,     1, 3, 1, 8'h05);
    vecs[8]  = mk(2'b01, 8'h05, 32'hAAAA,     8'h00, 32'h0,    1, 8'h05, 8'h05, 32'hDEADBEEF, 1, 2, 1, 8'h05);
    vecs[9]  = mk(2'b00, 8'h00, 32'h0,        8'h00, 32'h0,    0, 8'h00, 8'h05, 32'hDEADBEEF, 0, 2, 1, 8'h05);
    vecs[10] = mk(2'b01, 8'h20, 32'h2020,     8'h00, 32'h0,    1, 8'h20, 8'h20, 32'h2020,     1, 3, 1, 8'h05);
    vecs[11] = mk(2'b00, 8'h00, 32'h0,        8'h00, 32'h0,    0, 8'h00, 8'h20, 32'h2020,     1, 3, 1, 8'h05);
    vecs[12] = mk(2'b10, 8'h00, 32'h0,        8'h05, 32'h5555, 0, 8'h00, 8'h05, 32'h5555,     1, 4, 1, 8'h05);
    vecs[13] = mk(2'b00, 8'h00, 32'h0,        8'h00, 32'h0,    1, 8'h07, 8'h07, 32'h77,       1, 3, 1, 8'h05);
    vecs[14] = mk(2'b00, 8'h00, 32'h0,        8'h00, 32'h0,    1, 8'h07, 8'h07, 32'h77,       0, 3, 1, 8'h05);

    for (int i = 0; i < 5; i++) begin
      fill[i] = mk(2'b11, 8'(8'h40 + 2*i), 32'(32'hF000 + i), 8'(8'h41 + 2*i), 32'(32'hE000 + i),
                   0, 8'h00, 8'(8'h40 + 2*i), 32'(32'hF000 + i), 1, 9'(5 + 2*i), 1, 8'h05);
    end

    // Reset for one edge, then the sweep must keep ready low for exactly NUM_REGS cycles.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cnt = 0;
    while (ready !== 1'b1 && cnt < 2000) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    chk("reset_sweep_len", 64'(cnt), 64'(NUM_REGS));
    chk("reset_live_cnt", 64'(live_cnt), 64'd0);
    chk("reset_err", 64'(err), 64'd0);
    chk("reset_err_addr", 64'(err_addr), 64'd0);
    $display("[TB] reset sweep lasted %0d cycles", cnt);
    scan_invalid("reset_all_invalid");

    for (int i = 0; i < 15; i++) step(vecs[i], $sformatf("v%0d", i));
    for (int i = 0; i < 5; i++) step(fill[i], $sformatf("fill%0d", i));

    // Flush in RUN, then flush again during the 100th sweep cycle; a write mid-sweep is dropped.
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    low = 0;
    done = 1'b0;
    for (int p = 1; p <= 2000 && !done; p++) begin
      @(negedge clk);
      if (p == 100) flush = 1'b1;
      if (p == 5) begin
        wen = 2'b01; waddr = {8'h00, 8'h60}; wdata = {32'h0, 32'h6060}; raddr = {3{8'h60}};
      end
      #1;
      if (p == 5) begin
        chk("sweep_rdata", 64'(rdata), 64'd0);
        chk("sweep_rvalid", 64'(rvalid), 64'd0);
      end
      if (ready === 1'b1) done = 1'b1;
      else low++;
      if (!done) begin
        @(posedge clk);
        #1;
        flush = 1'b0;
        wen = '0;
      end
    end
    chk("flush_sweep_len", 64'(low), 64'(100 + NUM_REGS));
    chk("flush_live_cnt", 64'(live_cnt), 64'd0);
    chk("flush_err", 64'(err), 64'd0);
    chk("flush_err_addr", 64'(err_addr), 64'd0);
    $display("[TB] flush sweep lasted %0d cycles", low);
    scan_invalid("flush_all_invalid");

    // Two ports violating in the same cycle: the lower port index sets err_addr.
    step(mk(2'b11, 8'h30, 32'hA0, 8'h31, 32'hA1, 0, 8'h00, 8'h31, 32'hA1, 1, 2, 0, 8'h00), "pair_write");
    step(mk(2'b11, 8'h31, 32'hB0, 8'h30, 32'hB1, 0, 8'h00, 8'h30, 32'hA0, 1, 2, 1, 8'h31), "pair_violate");

    // Independent read ports addressing different IDs.
    @(negedge clk);
    raddr = {8'h32, 8'h31, 8'h30};
    #1;
    chk("multi_rvalid", 64'(rvalid), 64'(3'b011));
    chk("multi_rdata1", 64'(rdata[DATA_W +: DATA_W]), 64'(32'hA1));
    $display("[TB] multi-port read rvalid=%b", rvalid);

    // Reset overrides a simultaneous flush and write.
    @(negedge clk);
    rst_n = 1'b0; flush = 1'b1; wen = 2'b01; waddr = {8'h00, 8'h33}; wdata = {32'h0, 32'h3333};
    @(posedge clk);
    #1;
    rst_n = 1'b1; flush = 1'b0; wen = '0; raddr = {3{8'h33}};
    #1;
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_live_cnt", 64'(live_cnt), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    $display("[TB] reset during RUN ready=%b live=%0d", ready, live_cnt);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
